// File: rtl/pipeline_debug_controller_if.sv
// Debug-controller signal bundle.
// Groups the command handshake, pipeline enable/halt, register-bank debug
// read port, TX byte stream and debug observables of the pipeline debug
// controller.
//   master : the controller (drives o_* signals, samples i_* signals)
//   slave  : the surrounding system (command decoder, pipeline, bank, UART TX)
interface pipeline_debug_controller_if #(
  parameter int len                  = 32,
  parameter int NB_address_registros = 5,
  parameter int NB_CMD               = 2,
  parameter int NB_BYTE              = 8
) ();
  logic                            i_cmd_valid;
  logic [NB_CMD-1:0]               i_cmd;
  logic                            o_cmd_ready;
  logic                            i_halt;
  logic                            o_pipe_enable;
  logic [NB_address_registros-1:0] o_reg_rd_addr;
  logic [len-1:0]                  i_reg_rd_data;
  logic [NB_BYTE-1:0]              o_tx_data;
  logic                            o_tx_valid;
  logic                            i_tx_ready;
  logic [len-1:0]                  o_cycle_count;
  logic [2:0]                      o_state;

  modport master (
    input  i_cmd_valid, i_cmd, i_halt, i_reg_rd_data, i_tx_ready,
    output o_cmd_ready, o_pipe_enable, o_reg_rd_addr, o_tx_data, o_tx_valid,
           o_cycle_count, o_state
  );

  modport slave (
    output i_cmd_valid, i_cmd, i_halt, i_reg_rd_data, i_tx_ready,
    input  o_cmd_ready, o_pipe_enable, o_reg_rd_addr, o_tx_data, o_tx_valid,
           o_cycle_count, o_state
  );
endinterface

// File: rtl/pipeline_debug_controller.sv
// Pipeline debug controller.
// Sequences a 5-stage MIPS pipeline (free-run, single-step, halt when a HALT
// instruction retires), counts enabled cycles, and dumps the register bank
// followed by the cycle counter as an MSB-first byte stream.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   dbg (master) : command handshake (i_cmd_valid/i_cmd/o_cmd_ready),
//                  i_halt, o_pipe_enable, register read port
//                  (o_reg_rd_addr/i_reg_rd_data), TX stream
//                  (o_tx_data/o_tx_valid/i_tx_ready), o_cycle_count, o_state
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A producer holding valid keeps its data stable until that edge;
// ready may be driven combinationally and never depends on the other side's
// valid. Commands are only ready in IDLE and HALTED; elsewhere they wait.
module pipeline_debug_controller #(
  parameter int len                  = 32,
  parameter int cantidad_registros   = 32,
  parameter int NB_address_registros = 5,
  parameter int NB_CMD               = 2,
  parameter int NB_BYTE              = 8
) (
  input logic                    i_clk,
  input logic                    i_rst,
  pipeline_debug_controller_if.master dbg
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RUN       = 3'd1;
  localparam logic [2:0] S_STEP      = 3'd2;
  localparam logic [2:0] S_HALTED    = 3'd3;
  localparam logic [2:0] S_DUMP_ADDR = 3'd4;
  localparam logic [2:0] S_DUMP_WAIT = 3'd5;
  localparam logic [2:0] S_DUMP_SEND = 3'd6;

  localparam logic [NB_CMD-1:0] CMD_RUN   = NB_CMD'(0);
  localparam logic [NB_CMD-1:0] CMD_STEP  = NB_CMD'(1);
  localparam logic [NB_CMD-1:0] CMD_DUMP  = NB_CMD'(2);
  localparam logic [NB_CMD-1:0] CMD_CLEAR = NB_CMD'(3);

  localparam int BYTES_PER_WORD = len / NB_BYTE;
  localparam int BCW            = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int IDXW           = $clog2(cantidad_registros + 1);
  // Index value cantidad_registros stands for the trailing cycle-count word.
  localparam logic [IDXW-1:0] IDX_COUNT = IDXW'(cantidad_registros);
  localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BYTES_PER_WORD - 1);

  logic [2:0]                      state;
  logic [2:0]                      ret_state;
  logic [IDXW-1:0]                 idx;
  logic [BCW-1:0]                  byte_cnt;
  logic [len-1:0]                  shift_reg;
  logic [len-1:0]                  cycle_count;
  logic [NB_address_registros-1:0] reg_rd_addr;

  logic cmd_ready;
  logic cmd_fire;
  logic pipe_enable;
  logic tx_valid;

  assign cmd_ready   = (state == S_IDLE) || (state == S_HALTED);
  assign cmd_fire    = dbg.i_cmd_valid && cmd_ready;
  // The cycle in which HALT retires is itself not enabled, so nothing behind
  // it advances; a single step always gets its one enabled cycle.
  assign pipe_enable = ((state == S_RUN) && !dbg.i_halt) || (state == S_STEP);
  assign tx_valid    = (state == S_DUMP_SEND);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      ret_state   <= S_IDLE;
      idx         <= '0;
      byte_cnt    <= '0;
      shift_reg   <= '0;
      cycle_count <= '0;
      reg_rd_addr <= '0;
    end else begin
      if (pipe_enable) cycle_count <= cycle_count + len'(1);

      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            case (dbg.i_cmd)
              CMD_RUN:   state <= S_RUN;
              CMD_STEP:  state <= S_STEP;
              CMD_DUMP: begin
                state     <= S_DUMP_ADDR;
                idx       <= '0;
                ret_state <= S_IDLE;
              end
              CMD_CLEAR: cycle_count <= '0;
            endcase
          end
        end

        S_RUN: begin
          if (dbg.i_halt) state <= S_HALTED;
        end

        S_STEP: begin
          state <= dbg.i_halt ? S_HALTED : S_IDLE;
        end

        S_HALTED: begin
          // RUN and STEP are consumed but have no effect once halted.
          if (cmd_fire) begin
            if (dbg.i_cmd == CMD_DUMP) begin
              state     <= S_DUMP_ADDR;
              idx       <= '0;
              ret_state <= S_HALTED;
            end else if (dbg.i_cmd == CMD_CLEAR) begin
              cycle_count <= '0;
              state       <= S_IDLE;
            end
          end
        end

        S_DUMP_ADDR: begin
          if (idx != IDX_COUNT) reg_rd_addr <= idx[NB_address_registros-1:0];
          state <= S_DUMP_WAIT;
        end

        S_DUMP_WAIT: begin
          shift_reg <= (idx == IDX_COUNT) ? cycle_count : dbg.i_reg_rd_data;
          byte_cnt  <= '0;
          state     <= S_DUMP_SEND;
        end

        S_DUMP_SEND: begin
          if (dbg.i_tx_ready) begin
            shift_reg <= shift_reg << NB_BYTE;
            byte_cnt  <= byte_cnt + BCW'(1);
            if (byte_cnt == LAST_BYTE) begin
              if (idx == IDX_COUNT) begin
                state <= ret_state;
              end else begin
                idx   <= idx + IDXW'(1);
                state <= S_DUMP_ADDR;
              end
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg.o_cmd_ready   = cmd_ready;
  assign dbg.o_pipe_enable = pipe_enable;
  assign dbg.o_reg_rd_addr = reg_rd_addr;
  assign dbg.o_tx_data     = shift_reg[len-1 -: NB_BYTE];
  assign dbg.o_tx_valid    = tx_valid;
  assign dbg.o_cycle_count = cycle_count;
  assign dbg.o_state       = state;
endmodule
